// File: rtl/clockdivider_prog_if.sv
// -----------------------------------------------------------------------------
// clockdivider_prog_if
// Bundles the control inputs and divided-clock outputs of clockdivider_prog.
//   master : drives en/load/div, observes clk_out/tick/count (controller, bench)
//   slave  : the divider itself
// Signals:
//   en      [CH]        per-channel run enable
//   load    [CH]        per-channel divisor load strobe (one cycle)
//   div     [CH*DIV_W]  divisor bus, channel c at [c*DIV_W +: DIV_W]
//   clk_out [CH]        divided clocks
//   tick    [CH]        end-of-period pulse per channel
//   count   [CNT_W]     legacy free-running binary counter
// -----------------------------------------------------------------------------
interface clockdivider_prog_if #(
    parameter int CH    = 4,
    parameter int DIV_W = 8,
    parameter int CNT_W = 4
);
    logic [CH-1:0]       en;
    logic [CH-1:0]       load;
    logic [CH*DIV_W-1:0] div;
    logic [CH-1:0]       clk_out;
    logic [CH-1:0]       tick;
    logic [CNT_W-1:0]    count;

    modport master (
        output en, load, div,
        input  clk_out, tick, count
    );

    modport slave (
        input  en, load, div,
        output clk_out, tick, count
    );
endinterface

// File: rtl/clockdivider_prog.sv
// -----------------------------------------------------------------------------
// clockdivider_prog
// Multi-channel programmable clock divider. Each channel divides clk by its own
// active ratio Dact (2 .. 2^DIV_W-1), producing a registered divided clock and a
// one-cycle end-of-period tick. A new ratio is held pending and only adopted on
// a period boundary (counter wrap) or while the channel is disabled, so the
// divided clock never glitches. A free-running count bus keeps the legacy
// divide-by-2^(k+1) outputs.
//
// Ports:
//   clk  : system clock (rising edge; falling edge only with CLKDIV_ODD50_EN)
//   rst  : asynchronous active-low reset
//   bus  : clockdivider_prog_if.slave (en, load, div in; clk_out, tick, count out)
//
// Build option:
//   CLKDIV_ODD50_EN : when defined, odd ratios get 50% duty by ANDing the
//                     posedge clock with a negedge-delayed copy of itself.
//                     Undefined: odd ratios are high (D+1)/2, low (D-1)/2.
// -----------------------------------------------------------------------------
module clockdivider_prog #(
    parameter int CH      = 4,
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 2,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    clockdivider_prog_if.slave bus
);

    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'((DIV_RST < 2) ? 2 : DIV_RST);

    // Ratios below 2 cannot form a period with both a high and a low phase.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // -------------------------------------------------------------------------
    // Legacy free-running counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.count = count_q;

    // -------------------------------------------------------------------------
    // Divider channels
    // -------------------------------------------------------------------------
    logic [CH-1:0] clk_out_w;
    logic [CH-1:0] tick_w;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] cnt_d;
        logic [DIV_W-1:0] dact_q;
        logic [DIV_W-1:0] dact_d;
        logic [DIV_W-1:0] pend_q;
        logic [DIV_W-1:0] pend_d;
        logic [DIV_W-1:0] div_in;
        logic [DIV_W-1:0] half;
        logic             pend_vld_q;
        logic             pend_vld_d;
        logic             q_pos_q;
        logic             q_pos_d;
        logic             tick_q;
        logic             tick_d;
        logic             last;
        logic             apply;

        assign div_in = clamp_div(bus.div[c*DIV_W +: DIV_W]);

        // >= rather than == keeps the counter recoverable even if cnt were
        // ever above the terminal value.
        assign last  = (cnt_q >= (dact_q - DIV_W'(1)));

        // Period boundary, or a parked channel: safe points to change ratio.
        assign apply = !bus.en[c] || last;

        // Divisor bookkeeping. A load landing on an apply edge bypasses the
        // pending register so the very next period already uses it.
        always_comb begin
            dact_d     = dact_q;
            pend_d     = pend_q;
            pend_vld_d = pend_vld_q;
            if (apply) begin
                if (bus.load[c]) begin
                    dact_d = div_in;
                end else if (pend_vld_q) begin
                    dact_d = pend_q;
                end
                pend_vld_d = 1'b0;
            end else if (bus.load[c]) begin
                pend_d     = div_in;
                pend_vld_d = 1'b1;
            end
        end

        // High-phase length ceil(Dact/2) of the ratio in force after this edge.
        assign half = (dact_d >> 1) + {{(DIV_W-1){1'b0}}, dact_d[0]};

        // Counter and registered outputs. A disabled channel parks at its
        // terminal count so the first enabled edge wraps to 0 and starts a
        // fresh period.
        always_comb begin
            cnt_d   = cnt_q;
            q_pos_d = 1'b0;
            tick_d  = 1'b0;
            if (!bus.en[c]) begin
                cnt_d = dact_d - DIV_W'(1);
            end else begin
                cnt_d   = last ? '0 : (cnt_q + DIV_W'(1));
                q_pos_d = (cnt_d < half);
                tick_d  = (cnt_d == (dact_d - DIV_W'(1)));
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q      <= DIV_RST_V - DIV_W'(1);
                dact_q     <= DIV_RST_V;
                pend_q     <= DIV_RST_V;
                pend_vld_q <= 1'b0;
                q_pos_q    <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                dact_q     <= dact_d;
                pend_q     <= pend_d;
                pend_vld_q <= pend_vld_d;
                q_pos_q    <= q_pos_d;
                tick_q     <= tick_d;
            end
        end

`ifdef CLKDIV_ODD50_EN
        // Half-cycle delayed copy trims the extra half cycle of high time on
        // odd ratios; even ratios already split evenly and use q_pos directly.
        logic q_neg_q;

        always_ff @(negedge clk or negedge rst) begin
            if (!rst) begin
                q_neg_q <= 1'b0;
            end else begin
                q_neg_q <= q_pos_q;
            end
        end

        assign clk_out_w[c] = dact_q[0] ? (q_pos_q & q_neg_q) : q_pos_q;
`else
        assign clk_out_w[c] = q_pos_q;
`endif

        assign tick_w[c] = tick_q;
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;

endmodule

// File: tb/tb_clockdivider_prog.sv
module tb_clockdivider_prog;

    localparam int CH    = 4;
    localparam int DIV_W = 8;
    localparam int CNT_W = 4;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [3:0] eclk;
        logic [3:0] etick;
        logic [3:0] ecnt;
    } exp_t;

    bit                  clk = 1'b0;
    logic                rst;
    logic [CH*DIV_W-1:0] divv;
    logic [3:0]          exp_cnt;
    int                  total = 0;
    int                  bad   = 0;
    exp_t                q[$];
    exp_t                x;
    event                chk_ev;

    clockdivider_prog_if #(.CH(CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus();

    clockdivider_prog #(
        .CH(CH), .DIV_W(DIV_W), .DIV_RST(2), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compares the oldest expectation against the DUT outputs.
    always @(negedge clk or chk_ev) begin
        if (q.size() > 0) begin
            x = q.pop_front();
            total = total + 3;
            if ((bus.clk_out & x.mask) !== (x.eclk & x.mask)) begin
                bad = bad + 1;
                $display("FAIL %s clk_out got=%b want=%b (mask %b) t=%0t",
                         x.name, bus.clk_out, x.eclk, x.mask, $time);
            end
            if ((bus.tick & x.mask) !== (x.etick & x.mask)) begin
                bad = bad + 1;
                $display("FAIL %s tick got=%b want=%b (mask %b) t=%0t",
                         x.name, bus.tick, x.etick, x.mask, $time);
            end
            if (bus.count !== x.ecnt) begin
                bad = bad + 1;
                $display("FAIL %s count got=%0d want=%0d t=%0t",
                         x.name, bus.count, x.ecnt, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_div(input int ch, input int val);
        divv[ch*DIV_W +: DIV_W] = val[DIV_W-1:0];
        bus.div = divv;
    endtask

    // Drive inputs for the next edge, then queue the expected post-edge state.
    task automatic cyc(input logic [3:0] e, input logic [3:0] ld,
                       input logic [3:0] m, input logic [3:0] ec,
                       input logic [3:0] et, input string nm);
        bus.en   = e;
        bus.load = ld;
        @(posedge clk);
        if (rst) exp_cnt = exp_cnt + 4'd1;
        else     exp_cnt = 4'd0;
        q.push_back('{nm, m, ec, et, exp_cnt});
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        divv     = '0;
        bus.div  = divv;
        bus.en   = 4'hF;
        bus.load = 4'h0;
        exp_cnt  = 4'd0;

        // Reset held with all channels enabled.
        repeat (3) cyc(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, "rst_hold");

        // Release: count 1..15,0; idle channels stay low.
        rst = 1'b1;
        repeat (16) cyc(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, "cnt_run");

        // Channel 0 at reset ratio 2.
        repeat (3) begin
            cyc(4'h1, 4'h0, 4'h1, 4'h1, 4'h0, "d2_hi");
            cyc(4'h1, 4'h0, 4'h1, 4'h0, 4'h1, "d2_tick");
        end
        cyc(4'h0, 4'h0, 4'h1, 4'h0, 4'h0, "ch0_off");

        // Channel 1: load 4 while disabled, then reload 5 mid-period at cnt=1.
        set_div(1, 4);
        cyc(4'h0, 4'h2, 4'h2, 4'h0, 4'h0, "ch1_load4");
        cyc(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, "d4_c0");
        cyc(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, "d4_c1");
        set_div(1, 5);
        cyc(4'h2, 4'h2, 4'h2, 4'h0, 4'h0, "d4_c2_load5");
        cyc(4'h2, 4'h0, 4'h2, 4'h0, 4'h2, "d4_c3_tick");
        repeat (3) cyc(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, "d5_hi");
        cyc(4'h2, 4'h0, 4'h2, 4'h0, 4'h0, "d5_lo");
        cyc(4'h2, 4'h0, 4'h2, 4'h0, 4'h2, "d5_tick");
        cyc(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, "d5_next");
        cyc(4'h0, 4'h0, 4'h2, 4'h0, 4'h0, "ch1_off");

        // Channel 2: ratios 0 and 1 clamp to 2.
        set_div(2, 0);
        cyc(4'h0, 4'h4, 4'h4, 4'h0, 4'h0, "clamp0_load");
        repeat (2) begin
            cyc(4'h4, 4'h0, 4'h4, 4'h4, 4'h0, "clamp0_hi");
            cyc(4'h4, 4'h0, 4'h4, 4'h0, 4'h4, "clamp0_tick");
        end
        set_div(2, 1);
        cyc(4'h4, 4'h4, 4'h4, 4'h4, 4'h0, "clamp1_load");
        cyc(4'h4, 4'h0, 4'h4, 4'h0, 4'h4, "clamp1_tick");
        cyc(4'h4, 4'h0, 4'h4, 4'h4, 4'h0, "clamp1_hi");
        cyc(4'h4, 4'h0, 4'h4, 4'h0, 4'h4, "clamp1_tick");
        cyc(4'h0, 4'h0, 4'h4, 4'h0, 4'h0, "ch2_off");

        // Channel 3: load 7 exactly on a wrap edge, applies immediately.
        cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "c_d2_hi");
        cyc(4'h8, 4'h0, 4'h8, 4'h0, 4'h8, "c_d2_tick");
        set_div(3, 7);
        cyc(4'h8, 4'h8, 4'h8, 4'h8, 4'h0, "c_wrap_load7");
        for (int p = 0; p < 2; p++) begin
            if (p > 0) cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "d7_hi");
            repeat (3) cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "d7_hi");
            repeat (2) cyc(4'h8, 4'h0, 4'h8, 4'h0, 4'h0, "d7_lo");
            cyc(4'h8, 4'h0, 4'h8, 4'h0, 4'h8, "d7_tick");
        end

        // Drop en[3] mid-period, re-enable: fresh period from cnt=0.
        repeat (3) cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "d7_hi");
        cyc(4'h0, 4'h0, 4'h8, 4'h0, 4'h0, "en3_drop");
        cyc(4'h0, 4'h0, 4'h8, 4'h0, 4'h0, "en3_parked");
        repeat (4) cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "reen_hi");
        repeat (2) cyc(4'h8, 4'h0, 4'h8, 4'h0, 4'h0, "reen_lo");
        cyc(4'h8, 4'h0, 4'h8, 4'h0, 4'h8, "reen_tick");
        cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "reen_wrap_hi");

        // Reset asserted between edges while clk_out[3] is high.
        @(negedge clk);
        #1;
        rst     = 1'b0;
        exp_cnt = 4'd0;
        #1;
        q.push_back('{"async_rst", 4'hF, 4'h0, 4'h0, 4'h0});
        -> chk_ev;
        cyc(4'h0, 4'h0, 4'hF, 4'h0, 4'h0, "rst_held");

        // After reset channel 3 is back at ratio 2.
        rst = 1'b1;
        repeat (2) begin
            cyc(4'h8, 4'h0, 4'h8, 4'h8, 4'h0, "post_rst_hi");
            cyc(4'h8, 4'h0, 4'h8, 4'h0, 4'h8, "post_rst_tick");
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
